sync_arith_seq_4: RTL

SYNC_ARITH_SEQ_4 -- requirements
Module: sync_arith_seq_4

---
 rtl/sync_arith_seq_4.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sync_arith_seq_4.sv
// Command sequencer for sync_arith_unit_4: issue, wait one ALU cycle, capture, hand off.
// Define SYNC_ARITH_SEQ_ERR_COUNT_EN to build the errored-command counter; otherwise o_err_count is tied to 0.
module sync_arith_seq_4 #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [N-1:0] i_cmd_op,
    input  logic [M-1:0] i_cmd_a,
    input  logic [M-1:0] i_cmd_b,
    output logic [N-1:0] o_alu_op,
    output logic [M-1:0] o_alu_arg_A,
    output logic [M-1:0] o_alu_arg_B,
    input  logic [M-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [M-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic         o_rsp_err,
    output logic [7:0]   o_cmd_count,
    output logic [7:0]   o_err_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t       state_reg;
    logic         cmd_ready_reg;
    logic         rsp_valid_reg;
    logic [N-1:0] alu_op_reg;
    logic [M-1:0] alu_a_reg;
    logic [M-1:0] alu_b_reg;
    logic [M-1:0] rsp_result_reg;
    logic [3:0]   rsp_status_reg;
    logic         rsp_err_reg;
    logic [7:0]   cmd_count_reg;
`ifdef SYNC_ARITH_SEQ_ERR_COUNT_EN
    logic [7:0]   err_count_reg;
`endif

    // cmd_ready rises on the first edge after reset is released, so it stays low while reset is held.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg      <= IDLE;
            cmd_ready_reg  <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            alu_op_reg     <= '0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            rsp_result_reg <= '0;
            rsp_status_reg <= '0;
            rsp_err_reg    <= 1'b0;
            cmd_count_reg  <= '0;
`ifdef SYNC_ARITH_SEQ_ERR_COUNT_EN
            err_count_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_ready_reg && i_cmd_valid) begin
                        alu_op_reg    <= i_cmd_op;
                        alu_a_reg     <= i_cmd_a;
                        alu_b_reg     <= i_cmd_b;
                        cmd_ready_reg <= 1'b0;
                        state_reg     <= ISSUE;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // ALU registered its outputs on the edge ending ISSUE; take them verbatim.
                    rsp_result_reg <= i_alu_result;
                    rsp_status_reg <= i_alu_status;
                    rsp_err_reg    <= i_alu_status[3];
                    rsp_valid_reg  <= 1'b1;
                    state_reg      <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                        if (cmd_count_reg != 8'hFF) begin
                            cmd_count_reg <= cmd_count_reg + 8'd1;
                        end
`ifdef SYNC_ARITH_SEQ_ERR_COUNT_EN
                        if (rsp_err_reg && (err_count_reg != 8'hFF)) begin
                            err_count_reg <= err_count_reg + 8'd1;
                        end
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready  = cmd_ready_reg;
    assign o_rsp_valid  = rsp_valid_reg;
    assign o_alu_op     = alu_op_reg;
    assign o_alu_arg_A  = alu_a_reg;
    assign o_alu_arg_B  = alu_b_reg;
    assign o_rsp_result = rsp_result_reg;
    assign o_rsp_status = rsp_status_reg;
    assign o_rsp_err    = rsp_err_reg;
    assign o_cmd_count  = cmd_count_reg;
`ifdef SYNC_ARITH_SEQ_ERR_COUNT_EN
    assign o_err_count  = err_count_reg;
`else
    assign o_err_count  = 8'h00;
`endif

endmodule
